seq_cu: RTL and testbench
=========================

Name: seq_cu

Overview:
- Multi-cycle sequencer for the 16-bit register-file/ALU datapath.
- Fetches instructions from instruction memory over a req/ack handshake and decodes the 7-bit opcode and three 3-bit register fields.
- Drives register-file read/write addresses, `alu_op` and `wr_en` one phase at a time.
- Sits between the instruction memory and the existing regfile/ALU; replaces the combinational decode for multi-instruction programs.

Parameters:
- PC_W, 8, program counter / imem address width.
- START_PC, 0, PC value after reset and on each restart.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin execution; sampled only in IDLE or HALT.
- imem_req  output  1  fetch request, registered.
- imem_addr  output  PC_W  fetch address; equals pc.
- imem_ack  input  1  fetch data valid this cycle.
- imem_data  input  16  instruction word.
- rf_ra  output  3  regfile read port A address (ir[8:6]).
- rf_rb  output  3  regfile read port B address (ir[5:3]).
- rf_wa  output  3  regfile write address (ir[2:0]).
- wr_en  output  1  regfile write enable.
- alu_op  output  2  ALU function: 00 add, 01 sub, 10 and, 11 or.
- busy  output  1  program executing.
- done  output  1  HALT reached.

Behaviour:
- Instruction format: op_code = [15:9], rs1 = [8:6], rs2 = [5:3], rd = [2:0].
- Opcodes:
  - 0x01 add, 0x02 sub, 0x03 and, 0x04 or.
  - 0x7F halt.
  - 0x00 and all other values are nop (no write).
- Reset (async, rst_n=0): state=IDLE, pc=START_PC, ir=0. All outputs 0: imem_req, wr_en, alu_op, rf_ra, rf_rb, rf_wa, busy, done. Reset mid-instruction drops wr_en and imem_req immediately.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE: start=1 -> FETCH, busy=1.
- FETCH:
  - imem_req=1 and imem_addr=pc, held stable until imem_ack.
  - On the cycle imem_ack=1 with req high: ir<=imem_data, go to DECODE; imem_req=0 from the next cycle.
  - imem_ack while req=0 is ignored.
  - Wait states are unbounded.
- DECODE:
  - rf_ra/rf_rb/rf_wa registered from ir.
  - ALU opcode -> EXEC.
  - halt -> HALT.
  - nop/unknown -> pc<=pc+1, FETCH.
- EXEC: alu_op driven from the opcode; register addresses held; 1 cycle -> WB.
- WB:
  - wr_en=1 for exactly this cycle with rf_wa=rd; alu_op and read addresses held.
  - pc<=pc+1; -> FETCH.
  - rd=0 is a legal write target.
- HALT:
  - busy=0, done=1; pc holds the halt address.
  - start=1 -> pc<=START_PC, done=0, busy=1, FETCH.
- start is ignored in FETCH/DECODE/EXEC/WB.
- pc arithmetic is modulo 2^PC_W (wraps from all-ones to 0).
- Latency with zero-wait ack (ack in the first req cycle):
  - ALU instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - nop: 2 cycles.
  - halt: 2 cycles to done.
  - Each wait cycle on ack adds 1.
- wr_en is never high outside WB; alu_op is 0 outside EXEC/WB.

Optional Feature:
- Macro: SEQ_CU_PERF_CNT_EN.
- Defined:
  - Adds outputs cycle_cnt[15:0] (counts cycles with busy=1) and retire_cnt[15:0] (increments in WB and on each nop leaving DECODE).
  - Both saturate at 0xFFFF, clear on reset, and clear on each accepted start.
- Undefined: ports and logic absent; behaviour is otherwise identical.

Test Plan:
- Reset, then program {0x0240, 0xFE00} at pc 0,1 with zero-wait ack, start pulse -> wr_en high 1 cycle with rf_ra=1, rf_rb=0, rf_wa=0, alu_op=00; done=1 after 6 cycles total; pc=1.
- Program {0x0314, 0x0000, 0x0289, 0xFE00} -> writes rd=4 (ra=4, rb=2), then nop (no wr_en), then writes rd=1 (ra=2, rb=1); done asserted; exactly 2 wr_en pulses.
- imem_ack delayed 3 cycles on every fetch -> imem_req and imem_addr stable while waiting; each instruction takes +3 cycles; results identical to zero-wait.
- PC_W=3, START_PC=6, nops at 6 and 7, halt at 0 -> imem_addr sequence 6, 7, 0 (wrap), then done.
- rst_n low during WB -> wr_en falls without waiting for a clock edge; all outputs 0; a later start refetches from START_PC.
- With SEQ_CU_PERF_CNT_EN: first program -> retire_cnt=1, cycle_cnt=6; a restart from HALT clears both counters.

Source files
------------

// File: rtl/seq_cu.sv
// Multi-cycle sequencer: fetches over req/ack, decodes, and steps the regfile/ALU one phase per cycle.
// Optional performance counters (cycle_cnt, retire_cnt) are built when SEQ_CU_PERF_CNT_EN is defined.
module seq_cu #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] START_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  output logic [2:0]      rf_ra,
  output logic [2:0]      rf_rb,
  output logic [2:0]      rf_wa,
  output logic            wr_en,
  output logic [1:0]      alu_op,
  output logic            busy,
  output logic            done
`ifdef SEQ_CU_PERF_CNT_EN
  ,
  output logic [15:0]     cycle_cnt,
  output logic [15:0]     retire_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
  } state_e;

  localparam logic [6:0] OP_ADD  = 7'h01;
  localparam logic [6:0] OP_OR   = 7'h04;
  localparam logic [6:0] OP_HALT = 7'h7F;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [15:0]     r_ir;
  logic            r_imem_req;
  logic            r_wr_en;
  logic            r_busy;
  logic            r_done;
  logic [2:0]      r_rf_ra;
  logic [2:0]      r_rf_rb;
  logic [2:0]      r_rf_wa;
  logic [1:0]      r_alu_op;

  logic [6:0]      w_op;
  logic            w_is_alu;
  logic            w_is_halt;
  logic            w_is_nop;
  logic            w_start_acc;
  logic            w_fetch_done;

  assign w_op         = r_ir[15:9];
  assign w_is_alu     = (w_op >= OP_ADD) && (w_op <= OP_OR);
  assign w_is_halt    = (w_op == OP_HALT);
  assign w_is_nop     = !w_is_alu && !w_is_halt;
  assign w_start_acc  = start && ((r_state == S_IDLE) || (r_state == S_HALT));
  // An ack only counts while our own request is up; stray acks are dropped.
  assign w_fetch_done = (r_state == S_FETCH) && r_imem_req && imem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns w_state_nxt; a missing branch would infer a latch.
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_FETCH;
      S_FETCH:  if (w_fetch_done) w_state_nxt = S_DECODE;
      S_DECODE: begin
        if (w_is_alu)       w_state_nxt = S_EXEC;
        else if (w_is_halt) w_state_nxt = S_HALT;
        else                w_state_nxt = S_FETCH;
      end
      S_EXEC:   w_state_nxt = S_WB;
      S_WB:     w_state_nxt = S_FETCH;
      S_HALT:   if (start) w_state_nxt = S_FETCH;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Control outputs are registered from the next state so they line up with the phase they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
      r_pc       <= START_PC;
      r_ir       <= '0;
      r_imem_req <= 1'b0;
      r_wr_en    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rf_ra    <= '0;
      r_rf_rb    <= '0;
      r_rf_wa    <= '0;
      r_alu_op   <= '0;
    end else begin
      r_imem_req <= (w_state_nxt == S_FETCH);
      r_wr_en    <= (w_state_nxt == S_WB);
      r_done     <= (w_state_nxt == S_HALT);
      r_busy     <= (w_state_nxt == S_FETCH) || (w_state_nxt == S_DECODE) ||
                    (w_state_nxt == S_EXEC)  || (w_state_nxt == S_WB);

      if (w_fetch_done) r_ir <= imem_data;

      if (r_state == S_DECODE) begin
        r_rf_ra <= r_ir[8:6];
        r_rf_rb <= r_ir[5:3];
        r_rf_wa <= r_ir[2:0];
      end

      if ((r_state == S_DECODE) && w_is_alu) r_alu_op <= 2'(w_op - OP_ADD);
      else if (r_state == S_WB)              r_alu_op <= '0;

      if (w_start_acc)
        r_pc <= START_PC;
      else if ((r_state == S_WB) || ((r_state == S_DECODE) && w_is_nop))
        r_pc <= r_pc + 1'b1;
    end
  end

  assign imem_req  = r_imem_req;
  assign imem_addr = r_pc;
  assign rf_ra     = r_rf_ra;
  assign rf_rb     = r_rf_rb;
  assign rf_wa     = r_rf_wa;
  assign wr_en     = r_wr_en;
  assign alu_op    = r_alu_op;
  assign busy      = r_busy;
  assign done      = r_done;

`ifdef SEQ_CU_PERF_CNT_EN
  logic [15:0] r_cycle_cnt;
  logic [15:0] r_retire_cnt;
  logic        w_retire;

  assign w_retire = (r_state == S_WB) || ((r_state == S_DECODE) && w_is_nop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt  <= '0;
      r_retire_cnt <= '0;
    end else if (w_start_acc) begin
      r_cycle_cnt  <= '0;
      r_retire_cnt <= '0;
    end else begin
      if (r_busy && (r_cycle_cnt != 16'hFFFF))    r_cycle_cnt  <= r_cycle_cnt + 16'd1;
      if (w_retire && (r_retire_cnt != 16'hFFFF)) r_retire_cnt <= r_retire_cnt + 16'd1;
    end
  end

  assign cycle_cnt  = r_cycle_cnt;
  assign retire_cnt = r_retire_cnt;
`endif

endmodule

// File: tb/tb_seq_cu.sv
// Bench for seq_cu: an instruction-memory responder plus a program-level reference model.
// Covers directed programs, wait states, PC wrap, reset during writeback and random programs.
`timescale 1ns/1ps
module tb_seq_cu;

  typedef struct packed {
    logic [2:0] ra;
    logic [2:0] rb;
    logic [2:0] wa;
    logic [1:0] op;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data = '0;
  logic [2:0]  rf_ra, rf_rb, rf_wa;
  logic        wr_en;
  logic [1:0]  alu_op;
  logic        busy, done;
`ifdef SEQ_CU_PERF_CNT_EN
  logic [15:0] cycle_cnt, retire_cnt;
  logic [15:0] w_cycle_cnt, w_retire_cnt;
`endif

  logic        w_start;
  logic        w_req;
  logic [2:0]  w_addr;
  logic        w_ack = 1'b0;
  logic [15:0] w_data = '0;
  logic [2:0]  w_ra, w_rb, w_wa;
  logic        w_wr_en;
  logic [1:0]  w_alu_op;
  logic        w_busy, w_done;

  seq_cu #(.PC_W(8), .START_PC(8'd0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_wa(rf_wa), .wr_en(wr_en), .alu_op(alu_op),
    .busy(busy), .done(done)
`ifdef SEQ_CU_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
`endif
  );

  // Narrow instance with a non-zero start address to exercise PC wrap.
  seq_cu #(.PC_W(3), .START_PC(3'd6)) u_dut_w (
    .clk(clk), .rst_n(rst_n), .start(w_start),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_data(w_data),
    .rf_ra(w_ra), .rf_rb(w_rb), .rf_wa(w_wa), .wr_en(w_wr_en), .alu_op(w_alu_op),
    .busy(w_busy), .done(w_done)
`ifdef SEQ_CU_PERF_CNT_EN
    , .cycle_cnt(w_cycle_cnt), .retire_cnt(w_retire_cnt)
`endif
  );

  logic [15:0] mem   [256];
  logic [15:0] mem_w [8];
  int          wait_n   = 0;
  bit          spurious = 1'b0;
  int          checks   = 0;
  int          failures = 0;

  int          wcnt     = 0;
  logic [7:0]  first_addr;
  int          mon_errs = 0;
  int          fetch_q[$];
  int          w_fetch_q[$];
  wr_t         wr_q[$];
  wr_t         exp_q[$];
  int          zero_wait_cycles;

  // Memory responder and protocol monitor for the main instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      imem_ack = 1'b0;
      wcnt     = 0;
    end else begin
      if (wr_en) wr_q.push_back({rf_ra, rf_rb, rf_wa, alu_op});
      if (!busy && (wr_en || alu_op != 2'b00)) mon_errs++;
      if (imem_req) begin
        if (wcnt == 0) first_addr = imem_addr;
        else if (imem_addr !== first_addr) mon_errs++;
        if (wcnt >= wait_n) begin
          imem_ack  = 1'b1;
          imem_data = mem[imem_addr];
          fetch_q.push_back(int'(imem_addr));
          wcnt      = 0;
        end else begin
          imem_ack  = 1'b0;
          imem_data = 16'($urandom);
          wcnt++;
        end
      end else begin
        if (wcnt != 0) mon_errs++;
        imem_ack  = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
        imem_data = 16'($urandom);
        wcnt      = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && w_req) begin
      w_ack  = 1'b1;
      w_data = mem_w[w_addr];
      w_fetch_q.push_back(int'(w_addr));
    end else begin
      w_ack  = 1'b0;
    end
  end

  // Walks the program from address 0 using the instruction-set rules only.
  task automatic model_run(output int cyc, output int n_ret, output logic [7:0] hpc);
    logic [7:0] pc;
    logic [6:0] op;
    pc    = 8'd0;
    cyc   = 0;
    n_ret = 0;
    hpc   = 8'hxx;
    exp_q.delete();
    for (int s = 0; s < 1000; s++) begin
      op  = mem[pc][15:9];
      cyc += wait_n + 2;
      if (op == 7'h7F) begin
        hpc = pc;
        return;
      end
      if (op >= 7'd1 && op <= 7'd4) begin
        cyc += 2;
        exp_q.push_back({mem[pc][8:6], mem[pc][5:3], mem[pc][2:0], 2'(op - 7'd1)});
      end
      n_ret++;
      pc = pc + 8'd1;
    end
  endtask

  task automatic run_prog(input string name, output int cyc_meas);
    int cyc, n_ret, n, fb, wb, eb;
    logic [7:0] hpc;
    model_run(cyc, n_ret, hpc);
    fb = fetch_q.size();
    wb = wr_q.size();
    eb = mon_errs;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL %s busy_after_start: got %0b expected 1", name, busy);
    end
`ifdef SEQ_CU_PERF_CNT_EN
    checks++;
    if (cycle_cnt !== 16'd0 || retire_cnt !== 16'd0) begin
      failures++;
      $display("FAIL %s perf_clear: got cycle=%0d retire=%0d expected 0 0", name, cycle_cnt, retire_cnt);
    end
`endif
    n = 1;
    while (done !== 1'b1 && n < 5000) begin
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    start    = 1'b0;
    cyc_meas = n - 1;
    checks++;
    if (done !== 1'b1) begin
      failures++; $display("FAIL %s done_timeout: got done=%0b expected 1", name, done);
    end
    checks++;
    if (cyc_meas != cyc) begin
      failures++; $display("FAIL %s cycles: got %0d expected %0d", name, cyc_meas, cyc);
    end
    checks++;
    if (wr_q.size() - wb != exp_q.size()) begin
      failures++; $display("FAIL %s write_count: got %0d expected %0d", name, wr_q.size() - wb, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (wr_q[wb + i] !== exp_q[i]) begin
          failures++; $display("FAIL %s write%0d: got %h expected %h", name, i, wr_q[wb + i], exp_q[i]);
        end
      end
    end
    checks++;
    if (fetch_q.size() - fb != n_ret + 1) begin
      failures++; $display("FAIL %s fetch_count: got %0d expected %0d", name, fetch_q.size() - fb, n_ret + 1);
    end else begin
      checks++;
      if (fetch_q[fb] != 0) begin
        failures++; $display("FAIL %s first_fetch: got %0d expected 0", name, fetch_q[fb]);
      end
    end
    checks++;
    if (imem_addr !== hpc) begin
      failures++; $display("FAIL %s halt_pc: got %0d expected %0d", name, imem_addr, hpc);
    end
    checks++;
    if (busy !== 1'b0 || wr_en !== 1'b0 || imem_req !== 1'b0 || alu_op !== 2'b00) begin
      failures++;
      $display("FAIL %s halt_outputs: got busy=%0b wr_en=%0b req=%0b alu_op=%0d expected 0 0 0 0",
               name, busy, wr_en, imem_req, alu_op);
    end
    checks++;
    if (mon_errs != eb) begin
      failures++; $display("FAIL %s protocol: got %0d violations expected 0", name, mon_errs - eb);
    end
`ifdef SEQ_CU_PERF_CNT_EN
    checks++;
    if (cycle_cnt !== 16'(cyc) || retire_cnt !== 16'(n_ret)) begin
      failures++;
      $display("FAIL %s perf_counts: got cycle=%0d retire=%0d expected %0d %0d",
               name, cycle_cnt, retire_cnt, cyc, n_ret);
    end
`endif
  endtask

  task automatic load_prog(input logic [15:0] words[$]);
    for (int i = 0; i < 256; i++) mem[i] = 16'hFE00;
    foreach (words[i]) mem[i] = words[i];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({imem_req, wr_en, alu_op, rf_ra, rf_rb, rf_wa, busy, done, imem_addr} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got req=%0b wr=%0b op=%0d ra=%0d rb=%0d wa=%0d busy=%0b done=%0b addr=%0d expected all 0",
               imem_req, wr_en, alu_op, rf_ra, rf_rb, rf_wa, busy, done, imem_addr);
    end
    checks++;
    if ({w_req, w_wr_en, w_alu_op, w_ra, w_rb, w_wa, w_busy, w_done} !== '0 || w_addr !== 3'd6) begin
      failures++; $display("FAIL reset_narrow: got addr=%0d busy=%0b done=%0b expected 6 0 0", w_addr, w_busy, w_done);
    end
`ifdef SEQ_CU_PERF_CNT_EN
    checks++;
    if (cycle_cnt !== 16'd0 || retire_cnt !== 16'd0) begin
      failures++; $display("FAIL reset_perf: got %0d %0d expected 0 0", cycle_cnt, retire_cnt);
    end
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || imem_req !== 1'b0) begin
      failures++; $display("FAIL idle_hold: got busy=%0b req=%0b expected 0 0", busy, imem_req);
    end
  endtask

  task automatic test_first_program();
    int c;
    wait_n = 0;
    load_prog('{16'h0240, 16'hFE00});
    run_prog("first_program", c);
    checks++;
    if (c != 6) begin
      failures++; $display("FAIL first_program_latency: got %0d expected 6", c);
    end
  endtask

  task automatic test_two_writes();
    wait_n = 0;
    load_prog('{16'h0314, 16'h0000, 16'h0289, 16'hFE00});
    run_prog("two_writes", zero_wait_cycles);
  endtask

  task automatic test_wait_states();
    int c;
    wait_n = 3;
    load_prog('{16'h0314, 16'h0000, 16'h0289, 16'hFE00});
    run_prog("wait_states", c);
    checks++;
    if (c != zero_wait_cycles + 4 * 3) begin
      failures++; $display("FAIL wait_state_latency: got %0d expected %0d", c, zero_wait_cycles + 12);
    end
    wait_n = 0;
  endtask

  task automatic test_pc_wrap();
    int n, fb;
    for (int i = 0; i < 8; i++) mem_w[i] = 16'hFE00;
    mem_w[6] = 16'h0000;
    mem_w[7] = 16'h0A00;
    fb = w_fetch_q.size();
    @(negedge clk); w_start = 1'b1;
    @(negedge clk); w_start = 1'b0;
    n = 1;
    while (w_done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (w_done !== 1'b1 || n - 1 != 6) begin
      failures++; $display("FAIL pc_wrap_done: got done=%0b cycles=%0d expected 1 6", w_done, n - 1);
    end
    checks++;
    if (w_fetch_q.size() - fb != 3) begin
      failures++; $display("FAIL pc_wrap_fetches: got %0d expected 3", w_fetch_q.size() - fb);
    end else if (w_fetch_q[fb] != 6 || w_fetch_q[fb + 1] != 7 || w_fetch_q[fb + 2] != 0) begin
      failures++;
      $display("FAIL pc_wrap_sequence: got %0d,%0d,%0d expected 6,7,0", w_fetch_q[fb], w_fetch_q[fb + 1], w_fetch_q[fb + 2]);
    end
  endtask

  task automatic test_reset_in_wb();
    int n, c;
    spurious = 1'b0;
    wait_n   = 0;
    load_prog('{16'h0240, 16'hFE00});
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (wr_en !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (wr_en !== 1'b1) begin
      failures++; $display("FAIL reset_wb_reach: got wr_en=%0b expected 1", wr_en);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({imem_req, wr_en, alu_op, rf_ra, rf_rb, rf_wa, busy, done, imem_addr} !== '0) begin
      failures++;
      $display("FAIL reset_wb_outputs: got req=%0b wr=%0b op=%0d ra=%0d busy=%0b expected all 0",
               imem_req, wr_en, alu_op, rf_ra, busy);
    end
    @(negedge clk); rst_n = 1'b1;
    run_prog("after_reset", c);
  endtask

  task automatic test_random();
    int len, c;
    for (int iter = 0; iter < 8; iter++) begin
      for (int i = 0; i < 256; i++) mem[i] = 16'hFE00;
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(0, 3))
          0, 1:    mem[i] = {7'($urandom_range(1, 4)), 9'($urandom)};
          2:       mem[i] = {7'h00, 9'($urandom)};
          default: mem[i] = {7'($urandom_range(5, 126)), 9'($urandom)};
        endcase
      end
      mem[len] = {7'h7F, 9'($urandom)};
      wait_n   = $urandom_range(0, 3);
      spurious = 1'($urandom_range(0, 1));
      run_prog($sformatf("random%0d", iter), c);
    end
    spurious = 1'b0;
    wait_n   = 0;
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    w_start = 1'b0;
    test_reset();
    test_first_program();
    test_two_writes();
    test_wait_states();
    test_pc_wrap();
    test_reset_in_wb();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
